// File: rtl/tlx_cmd_arbiter.sv
// Round-robin arbiter sharing the AFU-to-TLX command path between the read and
// write engines, with a registered output stage and TLX command-credit gating.
module tlx_cmd_arbiter #(
  parameter int CREDW = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       tlx_afu_cmd_initial_credit,
  input  logic             tlx_afu_cmd_credit,
  input  logic             cmd_sent,
  output logic             tlx_afu_cmd_ready,
  input  logic             rd_cmd_valid,
  output logic             rd_cmd_ready,
  input  logic [7:0]       rd_cmd_opcode,
  input  logic [15:0]      rd_cmd_afutag,
  input  logic [67:0]      rd_cmd_ea_or_obj,
  input  logic [1:0]       rd_cmd_dl,
  input  logic [2:0]       rd_cmd_pl,
  input  logic [11:0]      rd_cmd_actag,
  input  logic [19:0]      rd_cmd_pasid,
  input  logic             wr_cmd_valid,
  output logic             wr_cmd_ready,
  input  logic [7:0]       wr_cmd_opcode,
  input  logic [15:0]      wr_cmd_afutag,
  input  logic [67:0]      wr_cmd_ea_or_obj,
  input  logic [1:0]       wr_cmd_dl,
  input  logic [2:0]       wr_cmd_pl,
  input  logic [11:0]      wr_cmd_actag,
  input  logic [19:0]      wr_cmd_pasid,
  output logic             tlx_i_cmd_valid,
  output logic [7:0]       tlx_i_cmd_opcode,
  output logic [15:0]      tlx_i_cmd_afutag,
  output logic [67:0]      tlx_i_cmd_ea_or_obj,
  output logic [1:0]       tlx_i_cmd_dl,
  output logic [2:0]       tlx_i_cmd_pl,
  output logic [11:0]      tlx_i_cmd_actag,
  output logic [19:0]      tlx_i_cmd_pasid,
  input  logic             tlx_cmd_s1_ready,
  output logic [CREDW-1:0] credit_cnt,
  output logic             credit_err
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [CREDW-1:0] CNT_MAX = '1;
  localparam logic [CREDW-1:0] CNT_ONE = CREDW'(1);
  localparam logic [CREDW-1:0] CNT_TWO = CREDW'(2);

  state_t           state_reg, state_next;
  logic [CREDW-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic             ready_d_reg;
  logic             rr_last_wr_reg;
  logic             load_en;
  logic             grant_rd, grant_wr;

  // ---------------- arbitration and output stage ----------------
  assign load_en = !tlx_i_cmd_valid || tlx_cmd_s1_ready;

  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (rd_cmd_valid && wr_cmd_valid) begin
      grant_rd = rr_last_wr_reg;
      grant_wr = !rr_last_wr_reg;
    end else begin
      grant_rd = rd_cmd_valid;
      grant_wr = wr_cmd_valid;
    end
  end

  assign rd_cmd_ready = load_en && grant_rd;
  assign wr_cmd_ready = load_en && grant_wr;

  // rr_last resets to wr so that rd wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last_wr_reg      <= 1'b1;
      tlx_i_cmd_valid     <= 1'b0;
      tlx_i_cmd_opcode    <= '0;
      tlx_i_cmd_afutag    <= '0;
      tlx_i_cmd_ea_or_obj <= '0;
      tlx_i_cmd_dl        <= '0;
      tlx_i_cmd_pl        <= '0;
      tlx_i_cmd_actag     <= '0;
      tlx_i_cmd_pasid     <= '0;
    end else if (load_en) begin
      if (grant_rd) begin
        rr_last_wr_reg      <= 1'b0;
        tlx_i_cmd_valid     <= 1'b1;
        tlx_i_cmd_opcode    <= rd_cmd_opcode;
        tlx_i_cmd_afutag    <= rd_cmd_afutag;
        tlx_i_cmd_ea_or_obj <= rd_cmd_ea_or_obj;
        tlx_i_cmd_dl        <= rd_cmd_dl;
        tlx_i_cmd_pl        <= rd_cmd_pl;
        tlx_i_cmd_actag     <= rd_cmd_actag;
        tlx_i_cmd_pasid     <= rd_cmd_pasid;
      end else if (grant_wr) begin
        rr_last_wr_reg      <= 1'b1;
        tlx_i_cmd_valid     <= 1'b1;
        tlx_i_cmd_opcode    <= wr_cmd_opcode;
        tlx_i_cmd_afutag    <= wr_cmd_afutag;
        tlx_i_cmd_ea_or_obj <= wr_cmd_ea_or_obj;
        tlx_i_cmd_dl        <= wr_cmd_dl;
        tlx_i_cmd_pl        <= wr_cmd_pl;
        tlx_i_cmd_actag     <= wr_cmd_actag;
        tlx_i_cmd_pasid     <= wr_cmd_pasid;
      end else begin
        tlx_i_cmd_valid     <= 1'b0;
      end
    end
  end

  // ---------------- credit FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= INIT;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      ready_d_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      ready_d_reg <= tlx_afu_cmd_ready;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      INIT: begin
        state_next = RUN;
        cnt_next   = {{(CREDW-4){1'b0}}, tlx_afu_cmd_initial_credit};
      end
      RUN: begin
        if (tlx_afu_cmd_credit && !cmd_sent) begin
          if (cnt_reg == CNT_MAX) err_next = 1'b1;
          else                    cnt_next = cnt_reg + CNT_ONE;
        end else if (cmd_sent && !tlx_afu_cmd_credit) begin
          if (cnt_reg == '0) err_next = 1'b1;
          else               cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // A single credit may already be spoken for by last cycle's ready.
  assign tlx_afu_cmd_ready = (state_reg == RUN) &&
                             ((cnt_reg >= CNT_TWO) || (cnt_reg == CNT_ONE && !ready_d_reg));

  assign credit_cnt = cnt_reg;
  assign credit_err = err_reg;

endmodule

// File: tb/tb_tlx_cmd_arbiter.sv
// Self-checking bench for tlx_cmd_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_tlx_cmd_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  tlx_afu_cmd_initial_credit = '0;
  logic        tlx_afu_cmd_credit = 1'b0;
  logic        cmd_sent = 1'b0;
  logic        tlx_afu_cmd_ready;
  logic        rd_cmd_valid = 1'b0, wr_cmd_valid = 1'b0;
  logic        rd_cmd_ready, wr_cmd_ready;
  logic [7:0]  rd_cmd_opcode = '0, wr_cmd_opcode = '0;
  logic [15:0] rd_cmd_afutag = '0, wr_cmd_afutag = '0;
  logic [67:0] rd_cmd_ea_or_obj = '0, wr_cmd_ea_or_obj = '0;
  logic [1:0]  rd_cmd_dl = '0, wr_cmd_dl = '0;
  logic [2:0]  rd_cmd_pl = '0, wr_cmd_pl = '0;
  logic [11:0] rd_cmd_actag = '0, wr_cmd_actag = '0;
  logic [19:0] rd_cmd_pasid = '0, wr_cmd_pasid = '0;
  logic        tlx_i_cmd_valid;
  logic [7:0]  tlx_i_cmd_opcode;
  logic [15:0] tlx_i_cmd_afutag;
  logic [67:0] tlx_i_cmd_ea_or_obj;
  logic [1:0]  tlx_i_cmd_dl;
  logic [2:0]  tlx_i_cmd_pl;
  logic [11:0] tlx_i_cmd_actag;
  logic [19:0] tlx_i_cmd_pasid;
  logic        tlx_cmd_s1_ready = 1'b0;
  logic [6:0]  credit_cnt;
  logic        credit_err;

  tlx_cmd_arbiter #(.CREDW(7)) dut (
    .clk(clk), .resetn(resetn),
    .tlx_afu_cmd_initial_credit(tlx_afu_cmd_initial_credit),
    .tlx_afu_cmd_credit(tlx_afu_cmd_credit), .cmd_sent(cmd_sent),
    .tlx_afu_cmd_ready(tlx_afu_cmd_ready),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_opcode(rd_cmd_opcode), .rd_cmd_afutag(rd_cmd_afutag),
    .rd_cmd_ea_or_obj(rd_cmd_ea_or_obj), .rd_cmd_dl(rd_cmd_dl), .rd_cmd_pl(rd_cmd_pl),
    .rd_cmd_actag(rd_cmd_actag), .rd_cmd_pasid(rd_cmd_pasid),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_opcode(wr_cmd_opcode), .wr_cmd_afutag(wr_cmd_afutag),
    .wr_cmd_ea_or_obj(wr_cmd_ea_or_obj), .wr_cmd_dl(wr_cmd_dl), .wr_cmd_pl(wr_cmd_pl),
    .wr_cmd_actag(wr_cmd_actag), .wr_cmd_pasid(wr_cmd_pasid),
    .tlx_i_cmd_valid(tlx_i_cmd_valid), .tlx_i_cmd_opcode(tlx_i_cmd_opcode),
    .tlx_i_cmd_afutag(tlx_i_cmd_afutag), .tlx_i_cmd_ea_or_obj(tlx_i_cmd_ea_or_obj),
    .tlx_i_cmd_dl(tlx_i_cmd_dl), .tlx_i_cmd_pl(tlx_i_cmd_pl),
    .tlx_i_cmd_actag(tlx_i_cmd_actag), .tlx_i_cmd_pasid(tlx_i_cmd_pasid),
    .tlx_cmd_s1_ready(tlx_cmd_s1_ready),
    .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the command held toward the context stage, which side
  // was served last, and the credit bookkeeping.
  bit           m_valid;
  logic [128:0] m_fields;
  bit           m_last_wr;
  bit           m_run;
  int           m_cnt;
  int           m_init;
  bit           m_err;
  bit           m_rdy_d;

  function automatic logic [128:0] dut_fields();
    return {tlx_i_cmd_opcode, tlx_i_cmd_afutag, tlx_i_cmd_ea_or_obj, tlx_i_cmd_dl,
            tlx_i_cmd_pl, tlx_i_cmd_actag, tlx_i_cmd_pasid};
  endfunction

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_fields();
    rd_cmd_opcode    = 8'($urandom);
    rd_cmd_afutag    = 16'($urandom);
    rd_cmd_ea_or_obj = {4'($urandom), $urandom, $urandom};
    rd_cmd_dl        = 2'($urandom);
    rd_cmd_pl        = 3'($urandom);
    rd_cmd_actag     = 12'($urandom);
    rd_cmd_pasid     = 20'($urandom);
    wr_cmd_opcode    = 8'($urandom);
    wr_cmd_afutag    = 16'($urandom);
    wr_cmd_ea_or_obj = {4'($urandom), $urandom, $urandom};
    wr_cmd_dl        = 2'($urandom);
    wr_cmd_pl        = 3'($urandom);
    wr_cmd_actag     = 12'($urandom);
    wr_cmd_pasid     = 20'($urandom);
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance model.
  task automatic step(input bit rv, input bit wv, input bit s1, input bit cr, input bit snt);
    bit load, g_rd, g_wr, e_rdy;
    logic [128:0] rdf, wrf;
    @(negedge clk);
    rd_cmd_valid = rv; wr_cmd_valid = wv; tlx_cmd_s1_ready = s1;
    tlx_afu_cmd_credit = cr; cmd_sent = snt;
    #1;
    rdf = {rd_cmd_opcode, rd_cmd_afutag, rd_cmd_ea_or_obj, rd_cmd_dl, rd_cmd_pl, rd_cmd_actag, rd_cmd_pasid};
    wrf = {wr_cmd_opcode, wr_cmd_afutag, wr_cmd_ea_or_obj, wr_cmd_dl, wr_cmd_pl, wr_cmd_actag, wr_cmd_pasid};
    load  = !m_valid || s1;
    g_rd  = rv && (!wv || m_last_wr);
    g_wr  = wv && !g_rd;
    e_rdy = m_run && (m_cnt >= 2 || (m_cnt == 1 && !m_rdy_d));
    chk("rd_cmd_ready", rd_cmd_ready, load && g_rd);
    chk("wr_cmd_ready", wr_cmd_ready, load && g_wr);
    chk("tlx_afu_cmd_ready", tlx_afu_cmd_ready, e_rdy);
    chk("tlx_i_cmd_valid", tlx_i_cmd_valid, m_valid);
    chk("tlx_i_cmd_fields", dut_fields(), m_fields);
    chk("credit_cnt", credit_cnt, m_cnt);
    chk("credit_err", credit_err, m_err);
    @(posedge clk);
    if (load) begin
      if (g_rd || g_wr) begin
        m_valid   = 1'b1;
        m_fields  = g_rd ? rdf : wrf;
        m_last_wr = g_wr;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_rdy_d = e_rdy;
    if (!m_run) begin
      m_run = 1'b1;
      m_cnt = m_init;
    end else begin
      m_cnt = m_cnt + int'(cr) - int'(snt);
      if (m_cnt < 0)   begin m_cnt = 0;   m_err = 1'b1; end
      if (m_cnt > 127) begin m_cnt = 127; m_err = 1'b1; end
    end
    #1;
  endtask

  task automatic do_reset(input int init);
    @(negedge clk);
    resetn = 1'b0;
    rd_cmd_valid = 1'b0; wr_cmd_valid = 1'b0; tlx_cmd_s1_ready = 1'b0;
    tlx_afu_cmd_credit = 1'b0; cmd_sent = 1'b0;
    tlx_afu_cmd_initial_credit = 4'(init);
    m_valid = 1'b0; m_fields = '0; m_last_wr = 1'b1; m_run = 1'b0;
    m_cnt = 0; m_init = init; m_err = 1'b0; m_rdy_d = 1'b0;
    #1;
    chk("rst_valid", tlx_i_cmd_valid, 1'b0);
    chk("rst_fields", dut_fields(), '0);
    chk("rst_cnt", credit_cnt, 0);
    chk("rst_err", credit_err, 1'b0);
    chk("rst_afu_ready", tlx_afu_cmd_ready, 1'b0);
    chk("rst_rd_ready", rd_cmd_ready, 1'b0);
    chk("rst_wr_ready", wr_cmd_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    bit rv, wv, s1, cr, snt;

    // Init with three credits.
    do_reset(3);
    step(0, 0, 1, 0, 0);
    chk("init_cnt", credit_cnt, 3);
    chk("init_ready", tlx_afu_cmd_ready, 1'b1);
    chk("init_err", credit_err, 1'b0);

    // Round-robin tie: rd, wr, rd, wr.
    for (int i = 0; i < 4; i++) begin
      rd_cmd_afutag = 16'hA000 + 16'(i);
      wr_cmd_afutag = 16'hB000 + 16'(i);
      step(1, 1, 1, 0, 0);
      chk("rr_afutag", tlx_i_cmd_afutag, (i % 2 == 0) ? 16'hA000 + 16'(i) : 16'hB000 + 16'(i));
    end

    // Backpressure holds a write command.
    wr_cmd_afutag = 16'h1234;
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      rd_cmd_afutag = 16'h5500 + 16'(i);
      wr_cmd_afutag = 16'h6600 + 16'(i);
      step(1, 1, 0, 0, 0);
      chk("bp_afutag", tlx_i_cmd_afutag, 16'h1234);
      chk("bp_rd_ready", rd_cmd_ready, 1'b0);
      chk("bp_wr_ready", wr_cmd_ready, 1'b0);
    end
    rd_cmd_afutag = 16'h7777;
    step(1, 1, 1, 0, 0);
    chk("bp_release_afutag", tlx_i_cmd_afutag, 16'h7777);

    // Single credit, reset while a command is held.
    do_reset(1);
    step(0, 0, 1, 0, 0);
    chk("one_ready_hi", tlx_afu_cmd_ready, 1'b1);
    step(0, 0, 1, 0, 1);
    chk("one_cnt_used", credit_cnt, 0);
    chk("one_ready_lo", tlx_afu_cmd_ready, 1'b0);
    step(0, 0, 1, 0, 0);
    chk("one_ready_still_lo", tlx_afu_cmd_ready, 1'b0);
    step(0, 0, 1, 1, 0);
    chk("one_cnt_back", credit_cnt, 1);
    chk("one_ready_back", tlx_afu_cmd_ready, 1'b1);

    // Simultaneous return and send at count 4.
    repeat (3) step(0, 0, 1, 1, 0);
    chk("sim_pre_cnt", credit_cnt, 4);
    step(0, 0, 1, 1, 1);
    chk("sim_cnt", credit_cnt, 4);
    chk("sim_err", credit_err, 1'b0);

    // Underflow is sticky.
    repeat (4) step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("uf_cnt", credit_cnt, 0);
    chk("uf_err", credit_err, 1'b1);
    step(0, 0, 1, 1, 0);
    chk("uf_cnt_ret", credit_cnt, 1);
    chk("uf_err_sticky", credit_err, 1'b1);

    // Overflow saturates at 127.
    do_reset(15);
    step(0, 0, 1, 0, 0);
    repeat (112) step(0, 0, 1, 1, 0);
    chk("of_cnt_max", credit_cnt, 127);
    chk("of_err_pre", credit_err, 1'b0);
    step(0, 0, 1, 1, 0);
    chk("of_cnt", credit_cnt, 127);
    chk("of_err", credit_err, 1'b1);

    // Randomized traffic with periodic resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) do_reset(int'($urandom_range(0, 15)));
      rand_fields();
      rv  = ($urandom % 10) < 6;
      wv  = ($urandom % 10) < 6;
      s1  = ($urandom % 10) < 7;
      cr  = ($urandom % 4) == 0;
      snt = (m_rdy_d && ($urandom % 4) != 0) || (($urandom % 32) == 0);
      step(rv, wv, s1, cr, snt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
